// File: rtl/faims_hv_regulator.sv
// Closed-loop FAIMS HV regulator: proportional, slew-limited, clamped coil work time with a sticky over-voltage fault.
// Optional feature: define FAIMS_HVREG_DEADBAND_EN to skip publishing while |err| <= DEADBAND.
module faims_hv_regulator #(
    parameter int SAMPLE_W   = 12,
    parameter int WORK_W     = 16,
    parameter int GAIN_SHIFT = 4,
    parameter int DEADBAND   = 4
) (
    input  logic                CLK,
    input  logic                i_reset_n,
    input  logic                i_enable,
    input  logic                i_sampleValid,
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic                o_sampleReady,
    input  logic [SAMPLE_W-1:0] i_setpoint,
    input  logic [SAMPLE_W-1:0] i_ovLimit,
    input  logic [WORK_W-1:0]   i_workMin,
    input  logic [WORK_W-1:0]   i_workMax,
    input  logic [WORK_W-1:0]   i_maxStep,
    input  logic                i_faultClear,
    output logic [WORK_W-1:0]   o_parWork,
    output logic                o_workUpdate,
    output logic                o_fault
);

    localparam int SW = WORK_W + 2;

    typedef enum logic [2:0] {IDLE, CALC, LIMIT, APPLY, PUBLISH} fsmState_t;

    fsmState_t state, nextState;

    logic                       readyReg;
    logic                       accept;
    logic                       skipPublish;
    logic [SAMPLE_W-1:0]        sampleReg;
    logic signed [SW-1:0]       stepReg;
    logic [WORK_W-1:0]          resultReg;
    logic signed [SAMPLE_W:0]   err;
    logic signed [SAMPLE_W:0]   errShift;
    logic signed [SW-1:0]       stepRaw;
    logic signed [SW-1:0]       stepLim;
    logic signed [SW-1:0]       maxS;
    logic signed [SW-1:0]       sum;
    logic signed [SW-1:0]       minS;
    logic signed [SW-1:0]       topS;
    logic [WORK_W-1:0]          clampRes;
    logic                       ov;

    // Handshake: a sample transfers on a rising edge where i_sampleValid and o_sampleReady
    // are both high; ready is offered only after a full idle cycle and only while enabled.
    assign o_sampleReady = readyReg & i_enable;
    assign accept        = i_sampleValid & o_sampleReady;

    assign err      = $signed({1'b0, i_setpoint}) - $signed({1'b0, sampleReg});
    assign errShift = err >>> GAIN_SHIFT;
    assign stepRaw  = {{(SW-SAMPLE_W-1){errShift[SAMPLE_W]}}, errShift};
    assign ov       = sampleReg > i_ovLimit;

    assign maxS = $signed({2'b00, i_maxStep});
    assign sum  = $signed({2'b00, o_parWork}) + stepReg;
    assign minS = $signed({2'b00, i_workMin});
    assign topS = $signed({2'b00, i_workMax});

`ifdef FAIMS_HVREG_DEADBAND_EN
    localparam logic signed [SAMPLE_W:0] DbLimit = (SAMPLE_W+1)'(DEADBAND);
    assign skipPublish = (err <= DbLimit) && (err >= -DbLimit) && !ov && !o_fault;
`else
    logic unusedDeadband;
    assign unusedDeadband = (DEADBAND != 0);
    assign skipPublish    = 1'b0;
`endif

    always_comb begin
        stepLim = stepReg;
        if (stepReg > maxS) begin
            stepLim = maxS;
        end else if (stepReg < -maxS) begin
            stepLim = -maxS;
        end
    end

    // An inverted clamp window (min > max) always resolves to the minimum.
    always_comb begin
        clampRes = sum[WORK_W-1:0];
        if (i_workMin > i_workMax) begin
            clampRes = i_workMin;
        end else if (sum < minS) begin
            clampRes = i_workMin;
        end else if (sum > topS) begin
            clampRes = i_workMax;
        end
    end

    always_ff @(posedge CLK or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = CALC;
            CALC:    nextState = skipPublish ? IDLE : LIMIT;
            LIMIT:   nextState = APPLY;
            APPLY:   nextState = PUBLISH;
            PUBLISH: nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (!i_enable) begin
            nextState = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge i_reset_n) begin
        if (!i_reset_n) begin
            readyReg     <= 1'b0;
            sampleReg    <= '0;
            stepReg      <= '0;
            resultReg    <= '0;
            o_parWork    <= '0;
            o_workUpdate <= 1'b0;
            o_fault      <= 1'b0;
        end else begin
            o_workUpdate <= 1'b0;
            readyReg     <= i_enable && (state == IDLE) && !accept;

            // A fresh over-voltage evaluation takes priority over a clear request.
            if (i_enable && (state == CALC) && ov) begin
                o_fault <= 1'b1;
            end else if (i_faultClear) begin
                o_fault <= 1'b0;
            end

            if (!i_enable) begin
                o_parWork <= i_workMin;
            end else begin
                case (state)
                    IDLE:    if (accept) sampleReg <= i_sample;
                    CALC:    stepReg <= stepRaw;
                    LIMIT:   stepReg <= stepLim;
                    APPLY:   resultReg <= clampRes;
                    PUBLISH: begin
                        o_parWork    <= o_fault ? i_workMin : resultReg;
                        o_workUpdate <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_faims_hv_regulator.sv
// Self-checking bench for faims_hv_regulator: transaction-level reference model, per-cycle compare,
// directed literal scenarios and randomized regulation traffic.
module tb_faims_hv_regulator;

    localparam int SAMPLE_W   = 12;
    localparam int WORK_W     = 16;
    localparam int GAIN_SHIFT = 4;
    localparam int DEADBAND   = 4;

    logic                CLK = 1'b0;
    logic                i_reset_n;
    logic                i_enable;
    logic                i_sampleValid;
    logic [SAMPLE_W-1:0] i_sample;
    logic                o_sampleReady;
    logic [SAMPLE_W-1:0] i_setpoint;
    logic [SAMPLE_W-1:0] i_ovLimit;
    logic [WORK_W-1:0]   i_workMin;
    logic [WORK_W-1:0]   i_workMax;
    logic [WORK_W-1:0]   i_maxStep;
    logic                i_faultClear;
    logic [WORK_W-1:0]   o_parWork;
    logic                o_workUpdate;
    logic                o_fault;

    always #5 CLK = ~CLK;

    faims_hv_regulator #(
        .SAMPLE_W(SAMPLE_W), .WORK_W(WORK_W), .GAIN_SHIFT(GAIN_SHIFT), .DEADBAND(DEADBAND)
    ) dut (
        .CLK(CLK), .i_reset_n(i_reset_n), .i_enable(i_enable),
        .i_sampleValid(i_sampleValid), .i_sample(i_sample), .o_sampleReady(o_sampleReady),
        .i_setpoint(i_setpoint), .i_ovLimit(i_ovLimit), .i_workMin(i_workMin),
        .i_workMax(i_workMax), .i_maxStep(i_maxStep), .i_faultClear(i_faultClear),
        .o_parWork(o_parWork), .o_workUpdate(o_workUpdate), .o_fault(o_fault)
    );

    int errors = 0;
    int checks = 0;
    bit compareEn = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the regulator must present, driven by transaction age.
    int mPar;
    bit mUpd, mFault, mReady, mBusy;
    int mAge, mSample;

    function automatic int floorShift(input int e);
        int d;
        d = 1 << GAIN_SHIFT;
        if (e >= 0) return e / d;
        return -((-e + d - 1) / d);
    endfunction

    function automatic int predictWork(input int par, input int sp, input int smp,
                                       input int maxStep, input int wMin, input int wMax);
        int step, sum;
        step = floorShift(sp - smp);
        if (step > maxStep) step = maxStep;
        if (step < -maxStep) step = -maxStep;
        sum = par + step;
        if (wMin > wMax) return wMin;
        if (sum < wMin) return wMin;
        if (sum > wMax) return wMax;
        return sum;
    endfunction

    int tPar, tAge, tSample;
    bit tUpd, tBusy, tAcc, tOvSet;

    always @(posedge CLK or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mPar <= 0; mUpd <= 0; mFault <= 0; mReady <= 0; mBusy <= 0; mAge <= 0; mSample <= 0;
        end else begin
            tPar = mPar; tUpd = 0; tBusy = mBusy; tAge = mAge; tSample = mSample; tOvSet = 0;
            tAcc = mReady && i_enable && i_sampleValid && !mBusy;
            if (!i_enable) begin
                tBusy = 0;
                tPar  = int'(i_workMin);
            end else if (mBusy) begin
                if (mAge == 0) begin
                    tOvSet = mSample > int'(i_ovLimit);
`ifdef FAIMS_HVREG_DEADBAND_EN
                    if ((int'(i_setpoint) - mSample <= DEADBAND) && (mSample - int'(i_setpoint) <= DEADBAND)
                        && !tOvSet && !mFault) tBusy = 0;
`endif
                end
                if (mAge == 3) begin
                    tPar = mFault ? int'(i_workMin)
                                  : predictWork(mPar, int'(i_setpoint), mSample, int'(i_maxStep),
                                                int'(i_workMin), int'(i_workMax));
                    tUpd  = 1;
                    tBusy = 0;
                end
                tAge = mAge + 1;
            end else if (tAcc) begin
                tBusy = 1; tAge = 0; tSample = int'(i_sample);
            end
            mPar    <= tPar;
            mUpd    <= tUpd;
            mBusy   <= tBusy;
            mAge    <= tAge;
            mSample <= tSample;
            mFault  <= tOvSet ? 1'b1 : (i_faultClear ? 1'b0 : mFault);
            mReady  <= i_enable && !mBusy && !tAcc;
        end
    end

    always @(negedge CLK) begin
        if (compareEn) begin
            check("parWork", 32'(o_parWork), 32'(mPar));
            check("workUpdate", 32'(o_workUpdate), 32'(mUpd));
            check("fault", 32'(o_fault), 32'(mFault));
            check("sampleReady", 32'(o_sampleReady), 32'(mReady & i_enable));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic setCfg(input int sp, input int ovl, input int wMin, input int wMax, input int mStep);
        i_setpoint = 12'(sp); i_ovLimit = 12'(ovl);
        i_workMin = 16'(wMin); i_workMax = 16'(wMax); i_maxStep = 16'(mStep);
    endtask

    // Returns one time unit after the accepting edge.
    task automatic sendSample(input int smp);
        bit ok, rdy;
        ok = 0;
        i_sample = 12'(smp);
        i_sampleValid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            rdy = o_sampleReady;
            @(posedge CLK);
            #1;
            if (rdy) ok = 1;
        end
        i_sampleValid = 1'b0;
        check("acceptWithinBudget", 32'(ok), 32'd1);
    endtask

    task automatic reloadMin();
        i_enable = 1'b0;
        tick(2);
        i_enable = 1'b1;
    endtask

    int slewExp[4] = '{60, 110, 120, 120};
    bit expDbStrobe;

    initial begin
        i_reset_n = 1'b0; i_enable = 1'b1; i_sampleValid = 1'b0; i_sample = '0;
        i_faultClear = 1'b0;
        setCfg(1000, 4095, 10, 5000, 100);
        #1;
        check("rstParWork", 32'(o_parWork), 32'd0);
        check("rstFault", 32'(o_fault), 32'd0);
        check("rstReady", 32'(o_sampleReady), 32'd0);
        check("rstUpdate", 32'(o_workUpdate), 32'd0);
        compareEn = 1'b1;
        @(posedge CLK); @(posedge CLK); #2;
        i_reset_n = 1'b1;
        #1 check("readyLowAtRelease", 32'(o_sampleReady), 32'd0);
        tick(1);
        check("readyOneEdgeAfterRelease", 32'(o_sampleReady), 32'd1);

        // Step up: 10 + ((1000-800) >>> 4) = 22
        reloadMin();
        check("startAtWorkMin", 32'(o_parWork), 32'd10);
        sendSample(800);
        tick(3);
        check("stepUpNoEarlyStrobe", 32'(o_workUpdate), 32'd0);
        tick(1);
        check("stepUpParWork", 32'(o_parWork), 32'd22);
        check("stepUpStrobe", 32'(o_workUpdate), 32'd1);
        tick(1);
        check("stepUpStrobeOneCycle", 32'(o_workUpdate), 32'd0);

        // Slew and clamp
        setCfg(4095, 4095, 10, 120, 50);
        reloadMin();
        for (int i = 0; i < 4; i++) begin
            sendSample(0);
            tick(4);
            check("slewParWork", 32'(o_parWork), 32'(slewExp[i]));
            check("slewStrobe", 32'(o_workUpdate), 32'd1);
        end

        // Over-voltage with clear held across the evaluation: set wins
        setCfg(1000, 3500, 10, 5000, 100);
        i_faultClear = 1'b1;
        sendSample(4000);
        tick(1);
        check("ovSetWinsOverClear", 32'(o_fault), 32'd1);
        i_faultClear = 1'b0;
        tick(3);
        check("ovParWorkMin", 32'(o_parWork), 32'd10);
        check("ovStrobe", 32'(o_workUpdate), 32'd1);
        check("ovFaultSticky", 32'(o_fault), 32'd1);
        i_faultClear = 1'b1;
        tick(1);
        i_faultClear = 1'b0;
        check("faultCleared", 32'(o_fault), 32'd0);
        sendSample(800);
        tick(4);
        check("resumeFromMin", 32'(o_parWork), 32'd22);

        // Enable drop mid-calculation
        sendSample(800);
        tick(2);
        i_enable = 1'b0;
        tick(1);
        check("dropParWorkMin", 32'(o_parWork), 32'd10);
        check("dropReady", 32'(o_sampleReady), 32'd0);
        check("dropNoStrobe", 32'(o_workUpdate), 32'd0);
        i_workMin = 16'd33;
        tick(1);
        check("disabledTracksMin", 32'(o_parWork), 32'd33);
        tick(2);
        check("dropStillNoStrobe", 32'(o_workUpdate), 32'd0);
        i_workMin = 16'd10;
        tick(1);
        i_enable = 1'b1;

        // Deadband boundary: err = 3
`ifdef FAIMS_HVREG_DEADBAND_EN
        expDbStrobe = 1'b0;
`else
        expDbStrobe = 1'b1;
`endif
        sendSample(997);
        tick(4);
        check("deadbandParWork", 32'(o_parWork), 32'd10);
        check("deadbandStrobe", 32'(o_workUpdate), 32'(expDbStrobe));

        // Asynchronous reset in flight with the fault set
        setCfg(1000, 3500, 10, 5000, 100);
        tick(2);
        sendSample(4000);
        tick(1);
        check("faultBeforeReset", 32'(o_fault), 32'd1);
        #2 i_reset_n = 1'b0;
        #1;
        check("midRstParWork", 32'(o_parWork), 32'd0);
        check("midRstFault", 32'(o_fault), 32'd0);
        check("midRstReady", 32'(o_sampleReady), 32'd0);
        check("midRstUpdate", 32'(o_workUpdate), 32'd0);
        @(posedge CLK); #2 i_reset_n = 1'b1;
        tick(1);
        check("readyAfterMidReset", 32'(o_sampleReady), 32'd1);

        // Randomized traffic; configuration only changes while no sample is in flight
        for (int t = 0; t < 300; t++) begin
            for (int k = 0; k < 20 && mBusy; k++) tick(1);
            setCfg($urandom_range(0, 4095),
                   ($urandom_range(0, 3) != 0) ? $urandom_range(3000, 4095) : $urandom_range(0, 4095),
                   ($urandom_range(0, 7) == 0) ? $urandom_range(60000, 65535) : $urandom_range(0, 3000),
                   ($urandom_range(0, 7) == 0) ? 65535 : $urandom_range(0, 6000),
                   $urandom_range(0, 300));
            for (int c = 0; c < int'($urandom_range(3, 12)); c++) begin
                i_sampleValid = 1'($urandom_range(0, 1));
                i_sample      = 12'($urandom_range(0, 4095));
                i_faultClear  = ($urandom_range(0, 7) == 0);
                i_enable      = ($urandom_range(0, 19) != 0);
                tick(1);
            end
            i_sampleValid = 1'b0;
            i_faultClear  = 1'b0;
            i_enable      = 1'b1;
        end
        tick(8);

        compareEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
